// File: rtl/wsb_pkg.sv
// Shared types and sizing helpers for the sliding-window shift buffer.
// Parallel load is enabled by defining WSB_PARALLEL_LOAD_EN.
package wsb_pkg;

  localparam int DATA_W_DEF = 8;
  localparam int DEPTH_DEF  = 4;

  typedef logic [DATA_W_DEF-1:0] sample_t;

  function automatic int cnt_w(input int depth);
    return $clog2(depth + 1);
  endfunction

endpackage

// File: rtl/wsb_need_counter.sv
// Fill-state counter: samples still needed before a window is valid.
// Parallel load (WSB_PARALLEL_LOAD_EN) forces the window complete.
module wsb_need_counter
  import wsb_pkg::*;
#(
  parameter int DEPTH  = DEPTH_DEF,
  parameter int STRIDE = 1,
  localparam int CW    = cnt_w(DEPTH)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          clr,
  input  logic          load,
  input  logic          in_valid,
  input  logic          win_ready,
  output logic          shift,
  output logic          in_ready,
  output logic          win_valid,
  output logic [CW-1:0] pending
);

  localparam logic [CW-1:0] DEPTH_C  = CW'(DEPTH);
  localparam logic [CW-1:0] STRIDE_C = CW'(STRIDE);

  logic [CW-1:0] need_q, need_d;
  logic          accept;

  assign win_valid = (need_q == '0);
  assign in_ready  = !win_valid | win_ready;
  assign shift     = in_valid & in_ready;
  assign accept    = win_valid & win_ready;
  assign pending   = need_q;

  // A shift in the accept cycle already counts toward the next stride.
  always_comb begin
    need_d = need_q;
    if (rst | clr)
      need_d = DEPTH_C;
    else if (load)
      need_d = '0;
    else if (accept)
      need_d = STRIDE_C - CW'(shift);
    else if (shift && need_q != '0)
      need_d = need_q - 1'b1;
  end

  always_ff @(posedge clk) begin
    need_q <= need_d;
  end

endmodule

// File: rtl/window_shift_buffer.sv
// Sliding-window shift buffer with valid/ready window handshake.
// Define WSB_PARALLEL_LOAD_EN to add the load/load_data ports.
module window_shift_buffer
  import wsb_pkg::*;
#(
  parameter int DATA_W = DATA_W_DEF,
  parameter int DEPTH  = DEPTH_DEF,
  parameter int STRIDE = 1
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    clr,
  input  logic                    in_valid,
  input  logic [DATA_W-1:0]       in_data,
  output logic                    in_ready,
  output logic                    win_valid,
  input  logic                    win_ready,
  input  logic                    last_mode,
  output logic [DATA_W-1:0]       win_data [0:DEPTH-1],
  output logic [cnt_w(DEPTH)-1:0] pending
`ifdef WSB_PARALLEL_LOAD_EN
  ,
  input  logic                    load,
  input  logic [DATA_W-1:0]       load_data [0:DEPTH-1]
`endif
);

  if (DEPTH < 2 || STRIDE < 1 || STRIDE > DEPTH) begin : g_bad_cfg
    $error("window_shift_buffer: need DEPTH>=2 and 1<=STRIDE<=DEPTH");
  end

`ifndef WSB_PARALLEL_LOAD_EN
  logic              load;
  logic [DATA_W-1:0] load_data [0:DEPTH-1];

  assign load = 1'b0;
  always_comb begin
    for (int i = 0; i < DEPTH; i++) load_data[i] = '0;
  end
`endif

  logic              shift;
  logic [DATA_W-1:0] mem_q [0:DEPTH-1];

  wsb_need_counter #(
    .DEPTH  (DEPTH),
    .STRIDE (STRIDE)
  ) u_cnt (
    .clk       (clk),
    .rst       (rst),
    .clr       (clr),
    .load      (load),
    .in_valid  (in_valid),
    .win_ready (win_ready),
    .shift     (shift),
    .in_ready  (in_ready),
    .win_valid (win_valid),
    .pending   (pending)
  );

  always_ff @(posedge clk) begin
    if (rst | clr) begin
      for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
    end else if (load) begin
      for (int i = 0; i < DEPTH; i++) mem_q[i] <= load_data[i];
    end else if (shift) begin
      for (int i = 0; i < DEPTH - 1; i++) mem_q[i] <= mem_q[i+1];
      mem_q[DEPTH-1] <= in_data;
    end
  end

  // Last mode exposes only the newest sample, in slot 0.
  always_comb begin
    for (int i = 0; i < DEPTH; i++)
      win_data[i] = last_mode ? '0 : mem_q[i];
    if (last_mode) win_data[0] = mem_q[DEPTH-1];
  end

endmodule

// File: tb/tb_window_shift_buffer.sv
// Self-checking bench for window_shift_buffer (DATA_W=8, DEPTH=4, STRIDE=2).
// Directed scenarios plus randomized traffic against a window/fill model.
module tb_window_shift_buffer;
  import wsb_pkg::*;

  localparam int DW = 8;
  localparam int DP = 4;
  localparam int ST = 2;

  logic          clk = 1'b0;
  logic          rst, clr, in_valid, win_ready, last_mode;
  logic [DW-1:0] in_data;
  logic          in_ready, win_valid;
  logic [DW-1:0] win_data [0:DP-1];
  logic [2:0]    pending;
  logic          load;
  logic [DW-1:0] load_data [0:DP-1];

  int n_checks = 0;
  int n_fail   = 0;

  // Model: last DP samples, samples required since last accept, samples seen.
  logic [DW-1:0] mw [0:DP-1];
  int            req, filled;

  always #5 clk = ~clk;

  window_shift_buffer #(
    .DATA_W (DW),
    .DEPTH  (DP),
    .STRIDE (ST)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .clr       (clr),
    .in_valid  (in_valid),
    .in_data   (in_data),
    .in_ready  (in_ready),
    .win_valid (win_valid),
    .win_ready (win_ready),
    .last_mode (last_mode),
    .win_data  (win_data),
    .pending   (pending)
`ifdef WSB_PARALLEL_LOAD_EN
    ,
    .load      (load),
    .load_data (load_data)
`endif
  );

  function automatic int m_pending();
    return req - filled;
  endfunction

  function automatic logic [DW-1:0] m_data(input int i);
    if (last_mode) return (i == 0) ? mw[DP-1] : '0;
    return mw[i];
  endfunction

  task automatic model_edge();
    bit mv, mir, sh, acc;
    mv  = (m_pending() == 0);
    mir = !mv || win_ready;
    sh  = in_valid && mir;
    acc = mv && win_ready;
    if (rst || clr) begin
      req = DP; filled = 0;
      for (int i = 0; i < DP; i++) mw[i] = '0;
    end else if (load) begin
      req = DP; filled = DP;
      for (int i = 0; i < DP; i++) mw[i] = load_data[i];
    end else begin
      if (sh) begin
        for (int i = 0; i < DP - 1; i++) mw[i] = mw[i+1];
        mw[DP-1] = in_data;
      end
      if (acc) begin
        req = ST; filled = sh ? 1 : 0;
      end else if (sh) begin
        filled++;
      end
    end
  endtask

  task automatic step();
    model_edge();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst = 1; clr = 0; in_valid = 0; in_data = '0;
    win_ready = 0; last_mode = 0; load = 0;
    for (int i = 0; i < DP; i++) load_data[i] = '0;
    step(); step();
    rst = 0; #1;
    n_checks++;
    if (in_ready !== 1'b1) begin
      n_fail++; $display("FAIL reset_in_ready: got %0b expected 1", in_ready);
    end
    n_checks++;
    if (win_valid !== 1'b0) begin
      n_fail++; $display("FAIL reset_win_valid: got %0b expected 0", win_valid);
    end
    n_checks++;
    if (pending !== 3'd4) begin
      n_fail++; $display("FAIL reset_pending: got %0d expected 4", pending);
    end
    for (int i = 0; i < DP; i++) begin
      n_checks++;
      if (win_data[i] !== 8'd0) begin
        n_fail++; $display("FAIL reset_data[%0d]: got %0d expected 0", i, win_data[i]);
      end
    end
  endtask

  task automatic test_fill();
    logic [DW-1:0] s [0:3];
    s = '{8'd11, 8'd22, 8'd33, 8'd44};
    in_valid = 1;
    for (int k = 0; k < 4; k++) begin
      in_data = s[k];
      step();
      n_checks++;
      if (pending !== 3'(3 - k)) begin
        n_fail++; $display("FAIL fill_pending[%0d]: got %0d expected %0d", k, pending, 3 - k);
      end
    end
    in_valid = 0; #1;
    n_checks++;
    if (win_valid !== 1'b1) begin
      n_fail++; $display("FAIL fill_valid: got %0b expected 1", win_valid);
    end
    for (int i = 0; i < DP; i++) begin
      n_checks++;
      if (win_data[i] !== s[i]) begin
        n_fail++; $display("FAIL fill_data[%0d]: got %0d expected %0d", i, win_data[i], s[i]);
      end
    end
  endtask

  task automatic test_stall();
    logic [DW-1:0] s [0:3];
    s = '{8'd11, 8'd22, 8'd33, 8'd44};
    win_ready = 0; in_valid = 1; in_data = 8'd55; #1;
    n_checks++;
    if (in_ready !== 1'b0) begin
      n_fail++; $display("FAIL stall_in_ready: got %0b expected 0", in_ready);
    end
    for (int c = 0; c < 3; c++) begin
      step();
      n_checks++;
      if (win_valid !== 1'b1 || pending !== 3'd0) begin
        n_fail++;
        $display("FAIL stall_state[%0d]: got valid=%0b pend=%0d expected 1/0", c, win_valid, pending);
      end
      for (int i = 0; i < DP; i++) begin
        n_checks++;
        if (win_data[i] !== s[i]) begin
          n_fail++; $display("FAIL stall_data[%0d]: got %0d expected %0d", i, win_data[i], s[i]);
        end
      end
    end
  endtask

  task automatic test_stride();
    logic [DW-1:0] s [0:3];
    s = '{8'd33, 8'd44, 8'd55, 8'd66};
    win_ready = 1; in_valid = 1; in_data = 8'd55; #1;
    n_checks++;
    if (in_ready !== 1'b1) begin
      n_fail++; $display("FAIL stride_in_ready: got %0b expected 1", in_ready);
    end
    step();
    n_checks++;
    if (pending !== 3'd1 || win_valid !== 1'b0) begin
      n_fail++;
      $display("FAIL stride_after_accept: got pend=%0d valid=%0b expected 1/0", pending, win_valid);
    end
    win_ready = 0; in_data = 8'd66;
    step();
    in_valid = 0; #1;
    n_checks++;
    if (win_valid !== 1'b1) begin
      n_fail++; $display("FAIL stride_valid: got %0b expected 1", win_valid);
    end
    for (int i = 0; i < DP; i++) begin
      n_checks++;
      if (win_data[i] !== s[i]) begin
        n_fail++; $display("FAIL stride_data[%0d]: got %0d expected %0d", i, win_data[i], s[i]);
      end
    end
  endtask

  task automatic test_last_mode();
    logic [DW-1:0] s [0:3];
    s = '{8'd66, 8'd0, 8'd0, 8'd0};
    last_mode = 1; #1;
    for (int i = 0; i < DP; i++) begin
      n_checks++;
      if (win_data[i] !== s[i]) begin
        n_fail++; $display("FAIL last_data[%0d]: got %0d expected %0d", i, win_data[i], s[i]);
      end
    end
    step();
    n_checks++;
    if (win_valid !== 1'b1 || pending !== 3'd0) begin
      n_fail++;
      $display("FAIL last_valid: got valid=%0b pend=%0d expected 1/0", win_valid, pending);
    end
    last_mode = 0;
  endtask

  task automatic test_clear();
    win_ready = 1; in_valid = 1; in_data = 8'd77;
    step();
    win_ready = 0; in_data = 8'd88;
    step();
    clr = 1; in_data = 8'd99;
    step();
    clr = 0; in_valid = 0; #1;
    n_checks++;
    if (pending !== 3'd4 || win_valid !== 1'b0) begin
      n_fail++;
      $display("FAIL clear_state: got pend=%0d valid=%0b expected 4/0", pending, win_valid);
    end
    for (int i = 0; i < DP; i++) begin
      n_checks++;
      if (win_data[i] !== 8'd0) begin
        n_fail++; $display("FAIL clear_data[%0d]: got %0d expected 0", i, win_data[i]);
      end
    end
  endtask

`ifdef WSB_PARALLEL_LOAD_EN
  task automatic test_load();
    load_data = '{8'd1, 8'd2, 8'd3, 8'd4};
    load = 1; in_valid = 1; in_data = 8'hEE;
    step();
    load = 0; in_valid = 0; #1;
    n_checks++;
    if (win_valid !== 1'b1) begin
      n_fail++; $display("FAIL load_valid: got %0b expected 1", win_valid);
    end
    for (int i = 0; i < DP; i++) begin
      n_checks++;
      if (win_data[i] !== 8'(i + 1)) begin
        n_fail++; $display("FAIL load_data[%0d]: got %0d expected %0d", i, win_data[i], i + 1);
      end
    end
    win_ready = 1;
    step();
    win_ready = 0; #1;
    n_checks++;
    if (pending !== 3'd2) begin
      n_fail++; $display("FAIL load_accept_pending: got %0d expected 2", pending);
    end
  endtask
`endif

  task automatic test_random();
    for (int c = 0; c < 600; c++) begin
      rst       = ($urandom_range(0, 99) == 0);
      clr       = ($urandom_range(0, 39) == 0);
      in_valid  = ($urandom_range(0, 3) != 0);
      win_ready = ($urandom_range(0, 2) != 0);
      last_mode = ($urandom_range(0, 7) == 0);
      in_data   = 8'($urandom);
`ifdef WSB_PARALLEL_LOAD_EN
      load = ($urandom_range(0, 49) == 0);
      for (int i = 0; i < DP; i++) load_data[i] = 8'($urandom);
`endif
      #1;
      n_checks++;
      if (win_valid !== (m_pending() == 0) || pending !== 3'(m_pending())) begin
        n_fail++;
        $display("FAIL rand_state[%0d]: got valid=%0b pend=%0d expected pend=%0d",
                 c, win_valid, pending, m_pending());
      end
      n_checks++;
      if (in_ready !== (m_pending() != 0 || win_ready)) begin
        n_fail++; $display("FAIL rand_in_ready[%0d]: got %0b", c, in_ready);
      end
      for (int i = 0; i < DP; i++) begin
        n_checks++;
        if (win_data[i] !== m_data(i)) begin
          n_fail++;
          $display("FAIL rand_data[%0d][%0d]: got %0d expected %0d", c, i, win_data[i], m_data(i));
        end
      end
      step();
    end
    rst = 0; clr = 0; in_valid = 0; load = 0;
  endtask

  initial begin
    req = DP; filled = 0;
    for (int i = 0; i < DP; i++) mw[i] = '0;
    test_reset();
    test_fill();
    test_stall();
    test_stride();
    test_last_mode();
    test_clear();
`ifdef WSB_PARALLEL_LOAD_EN
    test_load();
`endif
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
